// File: rtl/charge_timer.sv
// Coin-credit charging countdown: debounced coin/start buttons, second-resolution credit,
// BCD remaining-time digits. Define CHARGE_TIMER_CANCEL_EN to add a debounced cancel button.
module charge_timer #(
  parameter int unsigned TICKS_PER_SEC  = 1000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned COIN_SECS      = 30,
  parameter int unsigned IDLE_TIMEOUT_S = 10,
  parameter int unsigned DONE_HOLD_S    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_raw,
  input  logic       start_raw,
`ifdef CHARGE_TIMER_CANCEL_EN
  input  logic       cancel_raw,
`endif
  output logic       charging,
  output logic       done,
  output logic [1:0] state,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCredit   = 2'd1,
    StCharging = 2'd2,
    StDone     = 2'd3
  } state_e;

`ifdef CHARGE_TIMER_CANCEL_EN
  localparam int unsigned NumBtn = 3;
`else
  localparam int unsigned NumBtn = 2;
`endif
  localparam int unsigned DbW  = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned SecW = $clog2(TICKS_PER_SEC + 1);

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q, sync2_q, level_q, press_q;
  logic [DbW-1:0]    db_cnt_q [NumBtn];

`ifdef CHARGE_TIMER_CANCEL_EN
  assign raw = {cancel_raw, start_raw, coin_raw};
`else
  assign raw = {start_raw, coin_raw};
`endif

  // Level flips only after DEBOUNCE_MS+1 consecutive differing samples; press fires on 0->1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < NumBtn; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        if (sync2_q[i] != level_q[i]) begin
          if (db_cnt_q[i] == DbW'(DEBOUNCE_MS)) begin
            level_q[i]  <= sync2_q[i];
            press_q[i]  <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  logic coin_p, start_p, cancel_p;
  assign coin_p  = press_q[0];
  assign start_p = press_q[1];
`ifdef CHARGE_TIMER_CANCEL_EN
  assign cancel_p = press_q[2];
`else
  assign cancel_p = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [6:0]      remain_q, remain_d;
  logic [SecW-1:0] sec_q, sec_d;
  logic [7:0]      tcnt_q, tcnt_d;
  logic            sec_clr, tick;
  logic            charging_q, done_q;
  logic [3:0]      tens_q, ones_q;

  logic [7:0] sum_add, sum_chg;
  logic [6:0] sat_add, sat_chg;

  assign tick    = (sec_q == SecW'(TICKS_PER_SEC - 1));
  assign sum_add = {1'b0, remain_q} + (coin_p ? 8'(COIN_SECS) : 8'd0);
  assign sum_chg = sum_add - {7'd0, tick};
  assign sat_add = (sum_add > 8'd99) ? 7'd99 : sum_add[6:0];
  assign sat_chg = (sum_chg > 8'd99) ? 7'd99 : sum_chg[6:0];

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    tcnt_d   = tcnt_q;
    sec_clr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        remain_d = '0;
        if (coin_p) begin
          remain_d = 7'(COIN_SECS);
          state_d  = StCredit;
        end
      end
      StCredit: begin
        if (cancel_p) begin
          remain_d = '0;
          state_d  = StIdle;
        end else if (start_p) begin
          remain_d = sat_add;
          state_d  = StCharging;
        end else if (coin_p) begin
          // A coin restarts the inactivity window.
          remain_d = sat_add;
          sec_clr  = 1'b1;
          tcnt_d   = '0;
        end else if (tick) begin
          if (tcnt_q == 8'(IDLE_TIMEOUT_S - 1)) begin
            remain_d = '0;
            state_d  = StIdle;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      StCharging: begin
        if (cancel_p) begin
          remain_d = '0;
          state_d  = StIdle;
        end else begin
          remain_d = sat_chg;
          if (sat_chg == 7'd0) state_d = StDone;
        end
      end
      StDone: begin
        remain_d = '0;
        if (tick) begin
          if (tcnt_q == 8'(DONE_HOLD_S - 1)) begin
            state_d = StIdle;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      sec_clr = 1'b1;
      tcnt_d  = '0;
    end
    sec_d = (sec_clr || tick) ? '0 : sec_q + SecW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      remain_q   <= '0;
      sec_q      <= '0;
      tcnt_q     <= '0;
      charging_q <= 1'b0;
      done_q     <= 1'b0;
      tens_q     <= '0;
      ones_q     <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      sec_q      <= sec_d;
      tcnt_q     <= tcnt_d;
      charging_q <= (state_d == StCharging);
      done_q     <= (state_d == StDone);
      tens_q     <= 4'(remain_d / 7'd10);
      ones_q     <= 4'(remain_d % 7'd10);
    end
  end

  assign state       = state_q;
  assign charging    = charging_q;
  assign done        = done_q;
  assign remain_tens = tens_q;
  assign remain_ones = ones_q;

endmodule

// File: tb/tb_charge_timer.sv
// Bench for charge_timer: expected output snapshots are queued with a due cycle and
// compared by a monitor on the falling edge.
module tb_charge_timer;

  localparam int unsigned T  = 10;
  localparam int unsigned D  = 3;
  localparam int unsigned C  = 30;
  localparam int unsigned IT = 5;
  localparam int unsigned DH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_raw = 1'b0;
  logic       start_raw = 1'b0;
`ifdef CHARGE_TIMER_CANCEL_EN
  logic       cancel_raw = 1'b0;
`endif
  logic       charging, done;
  logic [1:0] state;
  logic [3:0] remain_tens, remain_ones;

  charge_timer #(
    .TICKS_PER_SEC (T),
    .DEBOUNCE_MS   (D),
    .COIN_SECS     (C),
    .IDLE_TIMEOUT_S(IT),
    .DONE_HOLD_S   (DH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_raw   (coin_raw),
    .start_raw  (start_raw),
`ifdef CHARGE_TIMER_CANCEL_EN
    .cancel_raw (cancel_raw),
`endif
    .charging   (charging),
    .done       (done),
    .state      (state),
    .remain_tens(remain_tens),
    .remain_ones(remain_ones)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       name;
    logic [11:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  // Snapshot layout: {state, charging, done, tens, ones}
  function automatic logic [11:0] snap(int st, int ch, int dn, int r);
    return {2'(st), 1'(ch), 1'(dn), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic expect_abs(string nm, int due, int st, int ch, int dn, int r);
    sb_t e;
    e.due  = due;
    e.name = nm;
    e.exp  = snap(st, ch, dn, r);
    sbq.push_back(e);
  endtask

  task automatic expect_in(string nm, int d, int st, int ch, int dn, int r);
    expect_abs(nm, cyc + d, st, ch, dn, r);
  endtask

  always @(negedge clk) begin
    logic [11:0] got;
    got = {state, charging, done, remain_tens, remain_ones};
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        n_cmp++;
        if (sbq[i].due < cyc || got !== sbq[i].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d (due %0d): got {st,chg,done,tens,ones}=%h required %h",
                   sbq[i].name, cyc, sbq[i].due, got, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) step(1);
  endtask

  task automatic do_reset();
    coin_raw  = 1'b0;
    start_raw = 1'b0;
`ifdef CHARGE_TIMER_CANCEL_EN
    cancel_raw = 1'b0;
`endif
    rst = 1'b1;
    step(1);
    expect_in("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(2);
  endtask

  // 0=coin 1=start 2=cancel; a clean 5-cycle press plus release settling. Effect at n+7.
  task automatic press(int which, output int n);
    n = cyc;
    if (which == 0) coin_raw = 1'b1;
    else if (which == 1) start_raw = 1'b1;
`ifdef CHARGE_TIMER_CANCEL_EN
    else cancel_raw = 1'b1;
`endif
    step(5);
    coin_raw  = 1'b0;
    start_raw = 1'b0;
`ifdef CHARGE_TIMER_CANCEL_EN
    cancel_raw = 1'b0;
`endif
    step(8);
  endtask

  typedef struct { int width; int st; int r; } wv_t;
  typedef struct { int coins; int r; } sv_t;
  typedef struct { int coins; int r_at; int r_after; } cv_t;

  wv_t wtab[5];
  sv_t stab[4];
  cv_t ctab[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e, t, j;
    wtab[0] = '{1, 0, 0};
    wtab[1] = '{2, 0, 0};
    wtab[2] = '{3, 0, 0};
    wtab[3] = '{4, 1, 30};
    wtab[4] = '{7, 1, 30};
    stab[0] = '{1, 30};
    stab[1] = '{2, 60};
    stab[2] = '{3, 90};
    stab[3] = '{4, 99};
    ctab[0] = '{3, 75, 99};
    ctab[1] = '{2, 40, 69};
    ctab[2] = '{1, 1, 30};

    step(3);

    // Debounce: glitches shorter than D+1 are dropped; accepted press lands 6 cycles after rise
    foreach (wtab[i]) begin
      do_reset();
      n = cyc;
      expect_abs("bounce_pre", n + 6, 0, 0, 0, 0);
      expect_abs("bounce_width", n + 7, wtab[i].st, 0, 0, wtab[i].r);
      coin_raw = 1'b1;
      step(wtab[i].width);
      coin_raw = 1'b0;
      wait_until(n + 20);
    end

    // Saturation in CREDIT, first decrement, then reset mid-charge
    do_reset();
    foreach (stab[i]) begin
      expect_in("credit_add", 7, 1, 0, 0, stab[i].r);
      press(0, n);
    end
    n = cyc;
    expect_abs("start_charge", n + 7, 2, 1, 0, 99);
    expect_abs("first_tick_pre", n + 16, 2, 1, 0, 99);
    expect_abs("first_tick", n + 17, 2, 1, 0, 98);
    press(1, n);
    wait_until(n + 19);
    expect_in("pre_reset", 0, 2, 1, 0, 98);
    rst = 1'b1;
    step(1);
    expect_in("reset_midcharge", 0, 0, 0, 0, 0);
    n_cmp++;
    if (state !== 2'd0 || charging !== 1'b0 || done !== 1'b0 ||
        remain_tens !== 4'd0 || remain_ones !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_midcharge_direct @cyc %0d: st=%0d chg=%b done=%b %0d/%0d",
               cyc, state, charging, done, remain_tens, remain_ones);
    end
    rst = 1'b0;
    step(2);

    // Countdown to DONE and hold back to IDLE; start in IDLE is ignored
    do_reset();
    expect_in("start_in_idle", 7, 0, 0, 0, 0);
    press(1, n);
    press(0, n);
    n = cyc;
    e = n + 7;
    expect_abs("charge_30", e, 2, 1, 0, 30);
    expect_abs("last_second", e + 299, 2, 1, 0, 1);
    expect_abs("done_enter", e + 300, 3, 0, 1, 0);
    expect_abs("done_hold", e + 319, 3, 0, 1, 0);
    expect_abs("done_exit", e + 320, 0, 0, 0, 0);
    press(1, n);
    wait_until(e + 325);

    // Coin landing on the tick edge
    foreach (ctab[i]) begin
      do_reset();
      for (int k = 0; k < ctab[i].coins; k++) press(0, n);
      n = cyc;
      e = n + 7;
      press(1, n);
      j = ctab[i].coins * C - ctab[i].r_at + 1;
      t = e + 10 * j;
      wait_until(t - 7);
      expect_abs("coin_tick_pre", t - 1, 2, 1, 0, ctab[i].r_at);
      expect_abs("coin_tick", t, 2, 1, 0, ctab[i].r_after);
      expect_abs("coin_tick_next", t + 10, 2, 1, 0, ctab[i].r_after - 1);
      press(0, n);
      wait_until(t + 12);
    end

    // Inactivity timeout in CREDIT
    do_reset();
    n = cyc;
    expect_abs("timeout_credit", n + 7, 1, 0, 0, 30);
    expect_abs("timeout_pre", n + 56, 1, 0, 0, 30);
    expect_abs("timeout_idle", n + 57, 0, 0, 0, 0);
    press(0, n);
    wait_until(n + 60);
    n_cmp++;
    if (state !== 2'd0 || remain_tens !== 4'd0 || remain_ones !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_direct @cyc %0d: st=%0d %0d/%0d",
               cyc, state, remain_tens, remain_ones);
    end

`ifdef CHARGE_TIMER_CANCEL_EN
    do_reset();
    press(0, n);
    n = cyc;
    e = n + 7;
    press(1, n);
    wait_until(e + 20);
    expect_in("cancel_pre", 6, 2, 1, 0, 28);
    expect_in("cancel_idle", 7, 0, 0, 0, 0);
    press(2, n);
    step(5);
`endif

    step(3);
    foreach (sbq[i]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: never compared (due %0d, now %0d)", sbq[i].name, sbq[i].due, cyc);
    end
    if (n_cmp < 12) begin
      n_fail++;
      $display("FAIL too_few_checks: only %0d compared", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
